// File: rtl/sensor_mode_cfg_seq_if.sv
// Register-write request/response bus between the mode sequencer
// and the I2C master.
interface sensor_mode_cfg_seq_if;
  logic        wr_valid_o;
  logic        wr_ready_i;
  logic [15:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        wr_resp_i;
  logic        wr_nack_i;

  modport master (
    output wr_valid_o,
    output wr_addr_o,
    output wr_data_o,
    input  wr_ready_i,
    input  wr_resp_i,
    input  wr_nack_i
  );

  modport slave (
    input  wr_valid_o,
    input  wr_addr_o,
    input  wr_data_o,
    output wr_ready_i,
    output wr_resp_i,
    output wr_nack_i
  );
endinterface

// File: rtl/sensor_mode_cfg_seq.sv
// Powers up the image sensor and streams its mode-register table
// to the I2C master, retrying NACKed writes.
module sensor_mode_cfg_seq #(
  parameter int ROM_DEPTH = 105,
  parameter logic [ROM_DEPTH-1:0][23:0] MODE_ROM = '0,
  parameter int PWRUP_CYCLES = 1_000_000,
  parameter int GAP_CYCLES = 100,
  parameter int MAX_RETRY = 3,
  localparam int IW = $clog2(ROM_DEPTH+1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          xclr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [IW-1:0] op_idx_o,
  sensor_mode_cfg_seq_if.master wr
);

  localparam int CMAX = (PWRUP_CYCLES > GAP_CYCLES) ?
                        PWRUP_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX+1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;
  localparam logic [CW-1:0] PW_LAST = CW'(PWRUP_CYCLES-1);
  localparam logic [CW-1:0] GAP_LAST =
    (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES-1);
  localparam logic [IW-1:0] IDX_END = IW'(ROM_DEPTH);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [RW-1:0]   r_retry, w_retry_n;
  logic [IW-1:0]   r_idx, w_idx_n;
  logic            r_xclr, w_xclr_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;
  logic            r_err, w_err_n;
  logic            r_valid, w_valid_n;
  logic [15:0]     r_addr, w_addr_n;
  logic [7:0]      r_data, w_data_n;
  logic [23:0]     w_rom;
  logic            w_hs;
  logic            w_active;

  always_comb begin
    w_rom = '0;
    for (int k = 0; k < ROM_DEPTH; k++) begin
      if (r_idx == IW'(k)) w_rom = MODE_ROM[k];
    end
  end

  assign w_hs = wr.wr_valid_o && wr.wr_ready_i;
  assign w_active = (r_state == S_PWRUP) || (r_state == S_ISSUE) ||
                    (r_state == S_WAIT) || (r_state == S_GAP);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_retry <= '0;
      r_idx   <= '0;
      r_xclr  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_retry <= w_retry_n;
      r_idx   <= w_idx_n;
      r_xclr  <= w_xclr_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      r_valid <= w_valid_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_retry_n = r_retry;
    w_idx_n   = r_idx;
    w_xclr_n  = r_xclr;
    w_busy_n  = r_busy;
    w_done_n  = r_done;
    w_err_n   = r_err;
    w_valid_n = r_valid;
    w_addr_n  = r_addr;
    w_data_n  = r_data;

    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          w_state_n = S_PWRUP;
          w_cnt_n   = '0;
          w_retry_n = '0;
          w_idx_n   = '0;
          w_done_n  = 1'b0;
          w_err_n   = 1'b0;
          w_xclr_n  = 1'b1;
          w_busy_n  = 1'b1;
        end
      end
      S_PWRUP: begin
        if (r_cnt == PW_LAST) begin
          w_state_n = S_ISSUE;
          w_valid_n = 1'b1;
          w_addr_n  = w_rom[23:8];
          w_data_n  = w_rom[7:0];
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_ISSUE: begin
        if (w_hs) begin
          w_state_n = S_WAIT;
          w_valid_n = 1'b0;
        end
      end
      S_WAIT: begin
        if (wr.wr_resp_i) begin
          w_cnt_n = '0;
          if (!wr.wr_nack_i) begin
            w_state_n = S_GAP;
            w_retry_n = '0;
            w_idx_n   = r_idx + IW'(1);
          end else if (r_retry < RETRY_MAX) begin
            w_state_n = S_GAP;
            w_retry_n = r_retry + RW'(1);
          end else begin
            w_state_n = S_ERROR;
            w_err_n   = 1'b1;
            w_busy_n  = 1'b0;
            w_xclr_n  = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (r_cnt >= GAP_LAST) begin
          if (r_idx == IDX_END) begin
            w_state_n = S_DONE;
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
          end else begin
            w_state_n = S_ISSUE;
            w_valid_n = 1'b1;
            w_addr_n  = w_rom[23:8];
            w_data_n  = w_rom[7:0];
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // abort overrides whatever the active state decided
    if (w_active && abort_i) begin
      w_state_n = S_ERROR;
      w_valid_n = 1'b0;
      w_err_n   = 1'b1;
      w_done_n  = 1'b0;
      w_busy_n  = 1'b0;
      w_xclr_n  = 1'b0;
    end
  end

  assign wr.wr_valid_o = r_valid & ~abort_i;
  assign wr.wr_addr_o  = r_addr;
  assign wr.wr_data_o  = r_data;
  assign xclr_o   = r_xclr;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign error_o  = r_err;
  assign op_idx_o = r_idx;

endmodule

// File: tb/tb_sensor_mode_cfg_seq.sv
// Directed bench: a queue of expected writes is filled by the
// stimulus and drained by a bus monitor at every handshake.
module tb_sensor_mode_cfg_seq;

  localparam int DEPTH = 3;
  localparam int IW = $clog2(DEPTH+1);
  localparam logic [DEPTH-1:0][23:0] ROM =
    {24'h0100_01, 24'h0343_C4, 24'h0342_5F};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic xclr, busy, done, err;
  logic [IW-1:0] op_idx;

  sensor_mode_cfg_seq_if bus();

  sensor_mode_cfg_seq #(
    .ROM_DEPTH(DEPTH),
    .MODE_ROM(ROM),
    .PWRUP_CYCLES(10),
    .GAP_CYCLES(2),
    .MAX_RETRY(3)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .abort_i(abort),
    .xclr_o(xclr),
    .busy_o(busy),
    .done_o(done),
    .error_o(err),
    .op_idx_o(op_idx),
    .wr(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [23:0] exp_q[$];
  bit nack_q[$];
  int resp_due = 0;
  int hs_count = 0;
  int first_v = -1;
  int start_cyc = 0;
  int stall_left = 0;
  int stall_seen = 0;
  logic [23:0] stall_word = 24'h0343_C4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // I2C master model and write monitor
  initial begin
    bus.wr_ready_i = 1'b1;
    bus.wr_resp_i = 1'b0;
    bus.wr_nack_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.wr_resp_i = 1'b0;
      bus.wr_nack_i = 1'b0;
      if (resp_due > 0) begin
        resp_due--;
        if (resp_due == 0) begin
          bus.wr_resp_i = 1'b1;
          bus.wr_nack_i = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        end
      end
      bus.wr_ready_i = !(stall_left > 0 && bus.wr_valid_o &&
                         bus.wr_addr_o == stall_word[23:8]);
      #1;
      if (rst_n && bus.wr_valid_o) begin
        if (first_v < 0) first_v = cyc;
        if (bus.wr_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write: unexpected %0h", {bus.wr_addr_o, bus.wr_data_o});
          end else begin
            chk("write", {8'h0, bus.wr_addr_o, bus.wr_data_o}, {8'h0, exp_q.pop_front()});
          end
          hs_count++;
          resp_due = 5;
        end else begin
          stall_left--;
          stall_seen++;
          chk("stall_hold", {8'h0, bus.wr_addr_o, bus.wr_data_o}, {8'h0, stall_word});
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_end(int lim);
    int n = 0;
    while (!(done || err) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", 32'(n < lim), 32'd1);
  endtask

  task automatic push_all();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ROM[i]);
  endtask

  task automatic chk_done(string tag);
    #2;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_xclr"}, 32'(xclr), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idx"}, 32'(op_idx), 32'd3);
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t0;
    int n;
    #3;
    chk("rst_xclr", 32'(xclr), 32'd0);
    chk("rst_valid", 32'(bus.wr_valid_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(op_idx), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: plain run
    push_all();
    first_v = -1;
    hs_count = 0;
    pulse_start();
    #2;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_xclr", 32'(xclr), 32'd1);
    wait_end(300);
    chk("t1_pwrup", 32'(first_v - start_cyc), 32'd10);
    chk("t1_hs", 32'(hs_count), 32'd3);
    chk_done("t1");

    // 2: ready stall on entry 1
    push_all();
    hs_count = 0;
    stall_seen = 0;
    stall_left = 7;
    pulse_start();
    wait_end(300);
    chk("t2_stall", 32'(stall_seen), 32'd7);
    chk("t2_hs", 32'(hs_count), 32'd3);
    chk_done("t2");

    // 3: two NACKs on entry 1 then ACK
    exp_q = {ROM[0], ROM[1], ROM[1], ROM[1], ROM[2]};
    nack_q = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    hs_count = 0;
    pulse_start();
    wait_end(400);
    chk("t3_hs", 32'(hs_count), 32'd5);
    chk_done("t3");

    // 4: entry 2 NACKed until retries run out
    exp_q = {ROM[0], ROM[1], ROM[2], ROM[2], ROM[2], ROM[2]};
    nack_q = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    hs_count = 0;
    pulse_start();
    wait_end(400);
    repeat (20) @(negedge clk);
    #2;
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_xclr", 32'(xclr), 32'd0);
    chk("t4_idx", 32'(op_idx), 32'd2);
    chk("t4_hs", 32'(hs_count), 32'd6);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5: abort while waiting for the response of entry 0
    nack_q.delete();
    exp_q = {ROM[0]};
    hs_count = 0;
    pulse_start();
    n = 0;
    while (hs_count == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_hs_timeout", 32'(n < 100), 32'd1);
    pulse_abort();
    #2;
    chk("t5_err_now", 32'(err), 32'd1);
    repeat (12) @(negedge clk);
    #2;
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_xclr", 32'(xclr), 32'd0);
    chk("t5_idx", 32'(op_idx), 32'd0);
    chk("t5_hs", 32'(hs_count), 32'd1);
    push_all();
    pulse_start();
    wait_end(300);
    chk_done("t5");

    // 6: async reset in power-up, start ignored while busy
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_xclr", 32'(xclr), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(bus.wr_valid_o), 32'd0);
    chk("t6_rst_idx", 32'(op_idx), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_all();
    first_v = -1;
    hs_count = 0;
    pulse_start();
    t0 = start_cyc;
    repeat (4) @(negedge clk);
    pulse_start();
    wait_end(300);
    chk("t6_pwrup", 32'(first_v - t0), 32'd10);
    chk("t6_hs", 32'(hs_count), 32'd3);
    chk_done("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
